plot_framebuffer: RTL

//  Receiving end of the pixel-plot interface (x, y, colour, plot strobe) driven by the fractal renderer.
//  - Stores each plotted pixel in an on-chip 3-bit-per-pixel frame memory.
//  - Provides a hardware clear that fills the frame with one colour.
//  - Streams the frame out in raster order over a valid/ready port for display or readback.
//  - Sits between the renderer and the display/readback logic.

---
 rtl/fb_pkg.sv | 30 +++
 rtl/plot_framebuffer_if.sv | 41 ++++
 rtl/fb_skid_buffer.sv | 64 ++++++
 rtl/plot_framebuffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared types, default geometry and state encodings for the plot framebuffer.
package fb_pkg;

  typedef logic [2:0] colour_t;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;

  typedef logic [0:0] clr_state_t;
  localparam clr_state_t C_IDLE = 1'b0;
  localparam clr_state_t C_FILL = 1'b1;

  typedef logic [1:0] rd_state_t;
  localparam rd_state_t R_IDLE  = 2'd0;
  localparam rd_state_t R_RUN   = 2'd1;
  localparam rd_state_t R_DRAIN = 2'd2;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    colour_t    colour;
    logic       last;
  } beat_t;

  function automatic logic [31:0] xy_to_addr(input logic [8:0] x, input logic [7:0] y,
                                             input int unsigned width);
    return width * 32'(y) + 32'(x);
  endfunction

endpackage

// File: rtl/plot_framebuffer_if.sv
// Plot, clear and raster-readout signals of the framebuffer; plot_oob exists only with FB_BOUNDS_CHECK_EN.
interface plot_framebuffer_if;
  import fb_pkg::*;

  logic [8:0]  vga_x;
  logic [7:0]  vga_y;
  colour_t     vga_colour;
  logic        vga_plot;
  logic        clear;
  colour_t     clear_colour;
  logic        clear_busy;
  logic [15:0] plot_dropped;
  logic        rd_start;
  logic        rd_busy;
  logic [8:0]  out_x;
  logic [7:0]  out_y;
  colour_t     out_colour;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
`ifdef FB_BOUNDS_CHECK_EN
  logic        plot_oob;
`endif

  modport master (
    output vga_x, vga_y, vga_colour, vga_plot, clear, clear_colour, rd_start, out_ready,
    input  clear_busy, plot_dropped, rd_busy, out_x, out_y, out_colour, out_valid, out_last
`ifdef FB_BOUNDS_CHECK_EN
    , input plot_oob
`endif
  );

  modport slave (
    input  vga_x, vga_y, vga_colour, vga_plot, clear, clear_colour, rd_start, out_ready,
    output clear_busy, plot_dropped, rd_busy, out_x, out_y, out_colour, out_valid, out_last
`ifdef FB_BOUNDS_CHECK_EN
    , output plot_oob
`endif
  );

endinterface

// File: rtl/fb_skid_buffer.sv
// Two-entry valid/ready buffer for readout beats; data visible the cycle after push,
// holds its head stable while stalled. The upstream only pushes when a slot is guaranteed.
module fb_skid_buffer
  import fb_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       in_vld_i,
  input  beat_t      in_dat_i,
  output logic       out_vld_o,
  input  logic       out_rdy_i,
  output beat_t      out_dat_o,
  output logic [1:0] level_o
);

  beat_t      ent0_q, ent0_d;
  beat_t      ent1_q, ent1_d;
  logic [1:0] cnt_q, cnt_d;
  logic       pop;

  assign pop       = out_vld_o && out_rdy_i;
  assign out_vld_o = (cnt_q != 2'd0);
  assign out_dat_o = ent0_q;
  assign level_o   = cnt_q;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({in_vld_i, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = in_dat_i;
        else               ent1_d = in_dat_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = in_dat_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = in_dat_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= '0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/plot_framebuffer.sv
// 3-bpp frame store: plot writes, hardware fill, raster readout (1-cycle RAM + skid buffer, 2-cycle issue-to-beat).
// Optional FB_BOUNDS_CHECK_EN discards out-of-range plots and raises a sticky plot_oob.
module plot_framebuffer
  import fb_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT
) (
  input logic               clk,
  input logic               rstn,
  plot_framebuffer_if.slave fb
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = $clog2(DEPTH);

  // ---------------- clear FSM ----------------
  clr_state_t    clr_state_q, clr_state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  colour_t       clr_colour_q, clr_colour_d;
  logic          filling;
  logic          clear_acc;

  assign filling   = (clr_state_q == C_FILL);
  assign clear_acc = (clr_state_q == C_IDLE) && fb.clear;

  always_comb begin
    clr_state_d  = clr_state_q;
    clr_addr_d   = clr_addr_q;
    clr_colour_d = clr_colour_q;
    case (clr_state_q)
      C_IDLE: begin
        if (fb.clear) begin
          clr_state_d  = C_FILL;
          clr_addr_d   = '0;
          clr_colour_d = fb.clear_colour;
        end
      end
      default: begin
        clr_addr_d = clr_addr_q + AW'(1);
        if (clr_addr_q == AW'(DEPTH - 1)) clr_state_d = C_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      clr_state_q  <= C_IDLE;
      clr_addr_q   <= '0;
      clr_colour_q <= '0;
    end else begin
      clr_state_q  <= clr_state_d;
      clr_addr_q   <= clr_addr_d;
      clr_colour_q <= clr_colour_d;
    end
  end

  // ---------------- plot path ----------------
  logic          plot_inb;
  logic [AW-1:0] plot_addr;
  logic [15:0]   plot_dropped_q, plot_dropped_d;

  assign plot_addr = AW'(xy_to_addr(fb.vga_x, fb.vga_y, WIDTH));

`ifdef FB_BOUNDS_CHECK_EN
  logic plot_oob_q, plot_oob_d;

  assign plot_inb = (int'(fb.vga_x) < WIDTH) && (int'(fb.vga_y) < HEIGHT);

  // A range violation in the same cycle as an accepted clear still sticks.
  always_comb begin
    plot_oob_d = plot_oob_q;
    if (clear_acc)                  plot_oob_d = 1'b0;
    if (fb.vga_plot && !plot_inb)   plot_oob_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) plot_oob_q <= 1'b0;
    else       plot_oob_q <= plot_oob_d;
  end

  assign fb.plot_oob = plot_oob_q;
`else
  assign plot_inb = 1'b1;
`endif

  always_comb begin
    plot_dropped_d = plot_dropped_q;
    if (fb.vga_plot && filling && plot_inb && (plot_dropped_q != 16'hFFFF))
      plot_dropped_d = plot_dropped_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) plot_dropped_q <= '0;
    else       plot_dropped_q <= plot_dropped_d;
  end

  // The fill owns the single write port while it runs.
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  colour_t       wr_dat;

  always_comb begin
    wr_en   = fb.vga_plot && plot_inb;
    wr_addr = plot_addr;
    wr_dat  = fb.vga_colour;
    if (filling) begin
      wr_en   = 1'b1;
      wr_addr = clr_addr_q;
      wr_dat  = clr_colour_q;
    end
  end

  // ---------------- readout FSM ----------------
  rd_state_t     rd_state_q, rd_state_d;
  logic [8:0]    rd_x_q, rd_x_d;
  logic [7:0]    rd_y_q, rd_y_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          rd_issue;
  logic          issue_last;
  logic          space_ok;
  logic          pop;
  logic [1:0]    sk_level;
  logic [1:0]    occ;

  logic          rs_vld_q;
  logic [8:0]    rs_x_q;
  logic [7:0]    rs_y_q;
  logic          rs_last_q;
  colour_t       rs_colour_q;

  // In-flight read plus buffered beats must fit in two slots; a pop this cycle frees one.
  assign pop        = fb.out_valid && fb.out_ready;
  assign occ        = sk_level + {1'b0, rs_vld_q};
  assign space_ok   = (occ < 2'd2) || pop;
  assign rd_issue   = (rd_state_q == R_RUN) && space_ok;
  assign issue_last = (rd_x_q == 9'(WIDTH - 1)) && (rd_y_q == 8'(HEIGHT - 1));

  always_comb begin
    rd_state_d = rd_state_q;
    rd_x_d     = rd_x_q;
    rd_y_d     = rd_y_q;
    rd_addr_d  = rd_addr_q;
    case (rd_state_q)
      R_IDLE: begin
        if (fb.rd_start && !filling) begin
          rd_state_d = R_RUN;
          rd_x_d     = '0;
          rd_y_d     = '0;
          rd_addr_d  = '0;
        end
      end
      R_RUN: begin
        if (rd_issue) begin
          rd_addr_d = rd_addr_q + AW'(1);
          if (issue_last) begin
            rd_state_d = R_DRAIN;
          end else if (rd_x_q == 9'(WIDTH - 1)) begin
            rd_x_d = '0;
            rd_y_d = rd_y_q + 8'd1;
          end else begin
            rd_x_d = rd_x_q + 9'd1;
          end
        end
      end
      R_DRAIN: begin
        if (pop && fb.out_last) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_state_q <= R_IDLE;
      rd_x_q     <= '0;
      rd_y_q     <= '0;
      rd_addr_q  <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_x_q     <= rd_x_d;
      rd_y_q     <= rd_y_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rs_vld_q  <= 1'b0;
      rs_x_q    <= '0;
      rs_y_q    <= '0;
      rs_last_q <= 1'b0;
    end else begin
      rs_vld_q <= rd_issue;
      if (rd_issue) begin
        rs_x_q    <= rd_x_q;
        rs_y_q    <= rd_y_q;
        rs_last_q <= issue_last;
      end
    end
  end

  // ---------------- frame memory (read-first) ----------------
  colour_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en)    mem[wr_addr] <= wr_dat;
    if (rd_issue) rs_colour_q  <= mem[rd_addr_q];
  end

  beat_t sk_in;
  beat_t sk_out;

  assign sk_in = {rs_x_q, rs_y_q, rs_colour_q, rs_last_q};

  fb_skid_buffer u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .in_vld_i  (rs_vld_q),
    .in_dat_i  (sk_in),
    .out_vld_o (fb.out_valid),
    .out_rdy_i (fb.out_ready),
    .out_dat_o (sk_out),
    .level_o   (sk_level)
  );

  assign fb.out_x        = sk_out.x;
  assign fb.out_y        = sk_out.y;
  assign fb.out_colour   = sk_out.colour;
  assign fb.out_last     = sk_out.last;
  assign fb.rd_busy      = (rd_state_q != R_IDLE);
  assign fb.clear_busy   = filling;
  assign fb.plot_dropped = plot_dropped_q;

endmodule
